// File: rtl/par16_pkg.sv
// Shared definitions for the 16-bit parallel host-bus initiator: request opcodes,
// sync words, FSM encoding and slave command codes for the sequencer.
package par16_pkg;

  typedef enum logic [1:0] {
    OP_SYNC      = 2'b00,
    OP_WRITE     = 2'b01,
    OP_READ      = 2'b10,
    OP_WAIT_DONE = 2'b11
  } op_e;

  localparam logic [15:0] SYNC_WORD1 = 16'hB8B8;
  localparam logic [15:0] SYNC_WORD2 = 16'h8B8B;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC_CLK,
    S_SYNC_W1,
    S_SYNC_W2,
    S_W_SETUP,
    S_W_CLKLO,
    S_W_DATA,
    S_W_CLKHI,
    S_R_SETUP,
    S_R_CLKLO,
    S_R_CLKHI,
    S_WAIT_DONE
  } state_e;

  // Slave command codes, written as data words by the sequencer.
  localparam logic [7:0] CMD_SET_HASH_OP = 8'h01;
  localparam logic [7:0] CMD_SET_TARGET  = 8'h02;
  localparam logic [7:0] CMD_SET_PREFIX  = 8'h03;
  localparam logic [7:0] CMD_START       = 8'h04;
  localparam logic [7:0] CMD_STR_LEN     = 8'h05;

endpackage

// File: rtl/par16_in_sync.sv
// Two-flop synchronizer for the asynchronous slave status lines.
module par16_in_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/par16_master.sv
// Initiator for the 16-bit parallel host bus: turns single-word requests into
// phased bus_clk/bus_rnw/bus_data sequences. All bus outputs are registered.
module par16_master
  import par16_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 3,
  parameter int unsigned DONE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        bus_clk,
  output logic        bus_rnw,
  output logic [15:0] bus_data_out,
  output logic        bus_data_oe,
  input  logic [15:0] bus_data_in,
  input  logic        bus_done,
  input  logic        bus_match
);

  localparam logic [7:0]  PM1    = 8'(PHASE_CYCLES - 1);
  localparam logic [31:0] TO_LIM = 32'(DONE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hi2_q, hi2_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [15:0] word_q, word_d;
  logic        bclk_q, bclk_d;
  logic        rnw_q, rnw_d;
  logic [15:0] dout_q, dout_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        done_s, match_s, phase_end;

  par16_in_sync #(.W(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   ({bus_done, bus_match}),
    .q_o   ({done_s, match_s})
  );

  assign phase_end = (cnt_q == 8'd0);

  always_comb begin
    state_d     = state_q;
    // Free-running reload: every timed state exits on phase_end, so this
    // equals a load on entry; IDLE acceptance loads explicitly.
    cnt_d       = phase_end ? PM1 : cnt_q - 8'd1;
    hi2_d       = hi2_q;
    wcnt_d      = wcnt_q;
    word_d      = word_q;
    bclk_d      = bclk_q;
    rnw_d       = rnw_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        word_d = cmd_data;
        cnt_d  = PM1;
        wcnt_d = 32'd1;
        case (op_e'(cmd_op))
          OP_SYNC:  begin state_d = S_SYNC_CLK; bclk_d = 1'b1; rnw_d = 1'b0; end
          OP_WRITE: begin state_d = S_W_SETUP;  rnw_d = 1'b0; end
          OP_READ:  begin state_d = S_R_SETUP;  rnw_d = 1'b1; end
          default:  state_d = S_WAIT_DONE;
        endcase
      end
      S_SYNC_CLK: if (phase_end) begin state_d = S_SYNC_W1; dout_d = SYNC_WORD1; end
      S_SYNC_W1:  if (phase_end) begin state_d = S_SYNC_W2; dout_d = SYNC_WORD2; end
      S_SYNC_W2:  if (phase_end) state_d = S_IDLE;
      S_W_SETUP:  if (phase_end) begin state_d = S_W_CLKLO; bclk_d = 1'b0; end
      S_W_CLKLO:  if (phase_end) begin state_d = S_W_DATA; dout_d = word_q; end
      S_W_DATA:   if (phase_end) begin state_d = S_W_CLKHI; bclk_d = 1'b1; hi2_d = 1'b0; end
      // High phase is two counter passes so P up to 255 fits the 8-bit counter.
      S_W_CLKHI:  if (phase_end) begin
        if (hi2_q) state_d = S_IDLE;
        else       hi2_d   = 1'b1;
      end
      S_R_SETUP:  if (phase_end) begin state_d = S_R_CLKLO; bclk_d = 1'b0; end
      S_R_CLKLO:  if (phase_end) begin state_d = S_R_CLKHI; bclk_d = 1'b1; end
      S_R_CLKHI:  if (phase_end) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus_data_in;
        rsp_error_d = 1'b0;
      end
      S_WAIT_DONE: begin
        wcnt_d = wcnt_q + 32'd1;
        if (done_s) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {15'b0, match_s};
          rsp_error_d = 1'b0;
        end else if (DONE_TIMEOUT != 0 && wcnt_q >= TO_LIM) begin
          // Response lands DONE_TIMEOUT cycles after acceptance.
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 16'h0000;
          rsp_error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      hi2_q       <= 1'b0;
      wcnt_q      <= 32'd0;
      word_q      <= 16'h0000;
      bclk_q      <= 1'b1;
      rnw_q       <= 1'b0;
      dout_q      <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi2_q       <= hi2_d;
      wcnt_q      <= wcnt_d;
      word_q      <= word_d;
      bclk_q      <= bclk_d;
      rnw_q       <= rnw_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE) && !reset;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_error    = rsp_error_q;
  assign bus_clk      = bclk_q;
  assign bus_rnw      = rnw_q;
  assign bus_data_out = dout_q;
  assign bus_data_oe  = !rnw_q;

endmodule

// File: tb/tb_par16_master.sv
// Directed bench for par16_master (P=3, DONE_TIMEOUT=20): hand-checked
// waveforms for the corner cases, then a table of back-to-back requests.
module tb_par16_master;
  import par16_pkg::*;

  logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = 16'h0, bus_data_in = 16'h0;
  logic        bus_done = 1'b0, bus_match = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_error, bus_clk, bus_rnw, bus_data_oe;
  logic [15:0] rsp_data, bus_data_out;

  always #5 clk = ~clk;

  par16_master #(.PHASE_CYCLES(3), .DONE_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .bus_clk(bus_clk),
    .bus_rnw(bus_rnw), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .bus_data_in(bus_data_in), .bus_done(bus_done), .bus_match(bus_match)
  );

  int checks = 0, errors = 0;
  logic        trc_clk [0:100];
  logic        trc_rsp [0:100];
  logic [15:0] trc_dout[0:100];
  int          ready_j, rsp_cnt;
  logic [15:0] last_rsp;
  logic        last_err;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] din;
    int          done_at;
    logic        match;
    int          ready_j;
    int          rsp_n;
    logic [15:0] rsp_d;
    logic        rsp_e;
    logic        rnw;
    logic [15:0] dout;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request when ready and trace bus/response until cmd_ready returns.
  // j counts edges after the acceptance edge's preceding cycle (j=1 is first busy cycle).
  task automatic run_op(input logic [1:0] op, input logic [15:0] data, input logic [15:0] din,
                        input int done_at, input logic match);
    int guard = 0;
    while (!cmd_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    bus_data_in = din; bus_done = 1'b0; bus_match = match;
    rsp_cnt = 0; ready_j = -1; last_rsp = 16'h0; last_err = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (j == done_at) bus_done = 1'b1;
      trc_clk[j] = bus_clk; trc_dout[j] = bus_data_out; trc_rsp[j] = rsp_valid;
      if (rsp_valid) begin rsp_cnt++; last_rsp = rsp_data; last_err = rsp_error; end
      if (cmd_ready) begin ready_j = j; break; end
    end
    if (ready_j < 0) chk("ready_timeout", 32'(ready_j), 32'd0);
    bus_done = 1'b0;
  endtask

  initial begin
    int abort_rsp;
    logic [15:0] ed;
    logic ec;

    vecs[0] = '{OP_SYNC,      16'h0000, 16'h0000, -1, 1'b0, 10, 0, 16'h0000, 1'b0, 1'b0, 16'h8B8B};
    vecs[1] = '{OP_WRITE,     16'h0005, 16'h0000, -1, 1'b0, 16, 0, 16'h0000, 1'b0, 1'b0, 16'h0005};
    vecs[2] = '{OP_READ,      16'h0000, 16'h1234, -1, 1'b0, 10, 1, 16'h1234, 1'b0, 1'b1, 16'h0005};
    vecs[3] = '{OP_WAIT_DONE, 16'h0000, 16'h0000, 10, 1'b1, 13, 1, 16'h0001, 1'b0, 1'b1, 16'h0005};
    vecs[4] = '{OP_WRITE,     16'hFFFF, 16'h0000, -1, 1'b0, 16, 0, 16'h0000, 1'b0, 1'b0, 16'hFFFF};
    vecs[5] = '{OP_READ,      16'h0000, 16'hABCD, -1, 1'b0, 10, 1, 16'hABCD, 1'b0, 1'b1, 16'hFFFF};
    vecs[6] = '{OP_WAIT_DONE, 16'h0000, 16'h0000, 10, 1'b0, 13, 1, 16'h0000, 1'b0, 1'b1, 16'hFFFF};
    vecs[7] = '{OP_SYNC,      16'h0000, 16'h0000, -1, 1'b0, 10, 0, 16'h0000, 1'b0, 1'b0, 16'h8B8B};
    vecs[8] = '{OP_WAIT_DONE, 16'h0000, 16'h0000, -1, 1'b0, 20, 1, 16'h0000, 1'b1, 1'b0, 16'h8B8B};
    vecs[9] = '{OP_READ,      16'h0000, 16'h0F0F, -1, 1'b0, 10, 1, 16'h0F0F, 1'b0, 1'b1, 16'h8B8B};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_clk", 32'(bus_clk), 32'd1);
    chk("rst_bus_rnw", 32'(bus_rnw), 32'd0);
    chk("rst_oe", 32'(bus_data_oe), 32'd1);
    chk("rst_dout", 32'(bus_data_out), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_ready_in_reset", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_after", 32'(cmd_ready), 32'd1);

    // SYNC waveform
    run_op(OP_SYNC, 16'h0, 16'h0, -1, 1'b0);
    chk("sync_ready_j", 32'(ready_j), 32'd10);
    for (int j = 1; j <= 9; j++) begin
      ed = (j <= 3) ? 16'h0000 : (j <= 6) ? 16'hB8B8 : 16'h8B8B;
      chk($sformatf("sync_dout_c%0d", j), 32'(trc_dout[j]), 32'(ed));
      chk($sformatf("sync_clk_c%0d", j), 32'(trc_clk[j]), 32'd1);
    end

    // WRITE waveform: clk low 6 cycles, data 3 cycles before rise, high 6 cycles
    run_op(OP_WRITE, {8'h00, CMD_STR_LEN}, 16'h0, -1, 1'b0);
    chk("wr_ready_j", 32'(ready_j), 32'd16);
    chk("wr_rnw", 32'(bus_rnw), 32'd0);
    for (int j = 1; j <= 15; j++) begin
      ec = !(j >= 4 && j <= 9);
      ed = (j >= 7) ? 16'h0005 : 16'h8B8B;
      chk($sformatf("wr_clk_c%0d", j), 32'(trc_clk[j]), 32'(ec));
      chk($sformatf("wr_dout_c%0d", j), 32'(trc_dout[j]), 32'(ed));
    end

    // READ: rnw/oe from first cycle, single rsp pulse at cycle 10
    cmd_valid = 1'b1; cmd_op = OP_READ; bus_data_in = 16'h1234;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rd_rnw_c1", 32'(bus_rnw), 32'd1);
    chk("rd_oe_c1", 32'(bus_data_oe), 32'd0);
    rsp_cnt = 0;
    for (int j = 2; j <= 10; j++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_cnt++;
      if (j == 10) begin
        chk("rd_rsp_valid_c10", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_data_c10", 32'(rsp_data), 32'h1234);
        chk("rd_ready_c10", 32'(cmd_ready), 32'd1);
      end
    end
    @(posedge clk); #1;
    if (rsp_valid) rsp_cnt++;
    chk("rd_rsp_once", 32'(rsp_cnt), 32'd1);

    // Reset during W_DATA aborts without a response
    abort_rsp = 0;
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_data = 16'hA5A5;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (rsp_valid) abort_rsp++;
    end
    chk("abort_wdata_dout", 32'(bus_data_out), 32'hA5A5);
    chk("abort_wdata_clk", 32'(bus_clk), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid) abort_rsp++;
    chk("abort_clk", 32'(bus_clk), 32'd1);
    chk("abort_rnw", 32'(bus_rnw), 32'd0);
    chk("abort_oe", 32'(bus_data_oe), 32'd1);
    chk("abort_dout", 32'(bus_data_out), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    if (rsp_valid) abort_rsp++;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_no_rsp", 32'(abort_rsp), 32'd0);
    run_op(OP_SYNC, 16'h0, 16'h0, -1, 1'b0);
    chk("abort_sync_ready_j", 32'(ready_j), 32'd10);
    chk("abort_sync_dout", 32'(bus_data_out), 32'h8B8B);
    chk("abort_sync_rsp", 32'(rsp_cnt), 32'd0);

    // Back-to-back table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].data, vecs[i].din, vecs[i].done_at, vecs[i].match);
      chk($sformatf("v%0d_ready_j", i), 32'(ready_j), 32'(vecs[i].ready_j));
      chk($sformatf("v%0d_rsp_n", i), 32'(rsp_cnt), 32'(vecs[i].rsp_n));
      if (vecs[i].rsp_n != 0) begin
        chk($sformatf("v%0d_rsp_data", i), 32'(last_rsp), 32'(vecs[i].rsp_d));
        chk($sformatf("v%0d_rsp_err", i), 32'(last_err), 32'(vecs[i].rsp_e));
      end
      chk($sformatf("v%0d_clk", i), 32'(bus_clk), 32'd1);
      chk($sformatf("v%0d_rnw", i), 32'(bus_rnw), 32'(vecs[i].rnw));
      chk($sformatf("v%0d_oe", i), 32'(bus_data_oe), 32'(!vecs[i].rnw));
      chk($sformatf("v%0d_dout", i), 32'(bus_data_out), 32'(vecs[i].dout));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
